tensor_core_seq: RTL and testbench
==================================

// Module: tensor_core_seq
// PURPOSE
//  Sequencer for the 4x4 MMA datapath (D = A*B + C). Accepts a command for K
//  tile-steps and fetches one A/B tile pair per step. Issues each step to the
//  datapath with the running accumulator as C, captures the result back, and
//  returns the final 4x4 tile. Sits between the tile buffers and the datapath.
// PARAMETERS
//  DWIDTH   16  element width, IEEE-754 half by default
//  KW       8   width of K tile count; max 2**KW-1 steps per command
//  TIMEOUT  64  max cycles in EXEC waiting for mma_out_valid before abort
// PORTS
//  clk            in   1      clock, rising edge
//  rst_n          in   1      asynchronous active-low reset
//  cmd_valid      in   1      command request
//  cmd_ready      out  1      command accept (IDLE only)
//  cmd_k          in   KW     number of K tile-steps
//  cmd_c          in   256    initial C tile (TC_SEQ_BIAS_EN only)
//  ab_valid       in   1      A/B tile pair available
//  ab_ready       out  1      A/B pair accept (FETCH only)
//  a_tile,b_tile  in   256    [0:3][0:3][DWIDTH-1:0] operand tiles
//  mma_a,mma_b    out  256    registered operands to datapath
//  mma_c          out  256    accumulator register to datapath
//  mma_in_valid   out  1      level request to datapath
//  mma_c_out      in   256    datapath result
//  mma_out_valid  in   1      datapath result valid
//  res_valid      out  1      final tile valid
//  res_ready      in   1      final tile accept
//  res_c          out  256    final tile (= accumulator)
//  busy           out  1      state != IDLE
//  err_timeout    out  1      sticky; set on abort, cleared on next cmd accept
// BEHAVIOUR
//  Reset: state=IDLE; acc, mma_a, mma_b, remaining cnt, watchdog = 0. Outputs
//   after reset: cmd_ready=1, all other 1-bit outputs 0, buses 0.
//  FSM IDLE->(cmd hs)->FETCH, or ->DONE if cmd_k==0.
//   FETCH: ab_ready=1; on ab_valid&ab_ready, register A/B and go to EXEC.
//   EXEC: mma_in_valid=1 held with stable operands until mma_out_valid. That
//    cycle: acc<=mma_c_out, remaining-=1. Then FETCH if remaining!=0, else DONE.
//   DONE: res_valid=1 and res_c=acc, held stable until res_ready, then IDLE.
//  Combinational datapath gives 1 EXEC cycle; min 2 cycles per tile-step.
//   Pipelined datapaths are supported with no change.
//  mma_out_valid outside EXEC is ignored. cmd/ab signals outside their states
//   are ignored and not back-pressured beyond ready=0.
//  Watchdog counts EXEC cycles and resets on entry. At count==TIMEOUT:
//   err_timeout<=1, go IDLE with no res_valid; acc is not updated.
//  Accumulation arithmetic is entirely in the datapath; this block only routes.
//  rst_n low at any point: immediate return to reset values, no res_valid.
// CONFIGURATION
//  TC_SEQ_BIAS_EN defined: on cmd accept, acc<=cmd_c. With cmd_k==0,
//   res_c=cmd_c.
//  TC_SEQ_BIAS_EN undefined: cmd_c port absent; acc<=0 on cmd accept.
// STRUCTURE
//  Package tc_pkg: DWIDTH default, tile_t = logic [0:3][0:3][DWIDTH-1:0],
//   seq_state_t enum {IDLE,FETCH,EXEC,DONE}.
//  Sub-module tc_watchdog: clear/enable counter with TIMEOUT compare, expire out.
// TESTING (datapath stub: combinational MMA, or programmable latency)
//  1 cmd_k=1, A=identity (diag 16'h3C00), B=all 16'h4000 -> one mma_in_valid
//    pulse; res_c=all 16'h4000.
//  2 cmd_k=3, 2-cycle gaps in ab_valid -> 3 EXEC phases; mma_c of step n equals
//    result of step n-1; res_valid only after step 3.
//  3 cmd_k=0 -> res_valid the cycle after accept, res_c=0 (bias build: cmd_c);
//    mma_in_valid never asserts.
//  4 res_ready low 5 cycles in DONE -> res_c stable, cmd_ready=0, busy=1;
//    accept -> IDLE next cycle.
//  5 stub never returns, TIMEOUT=16 -> err_timeout after 16 EXEC cycles, IDLE,
//    no res_valid; next cmd clears err_timeout.
//  6 rst_n low mid-EXEC at latency 4 -> mma_in_valid, busy 0 asynchronously;
//    late mma_out_valid ignored.

Source files
------------

// File: rtl/tc_pkg.sv
// tc_pkg: shared types and defaults for the tensor core sequencer.
package tc_pkg;
    localparam int DWIDTH = 16;
    typedef logic [0:3][0:3][DWIDTH-1:0] tile_t;
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} seq_state_t;
endpackage

// File: rtl/tc_watchdog.sv
// tc_watchdog: counts enabled cycles and flags expiry on the TIMEOUT-th one.
module tc_watchdog
    import tc_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;
    // r_cnt holds the cycles already spent, so the current cycle is r_cnt+1
    assign o_expire = i_en && (r_cnt == CW'(TIMEOUT - 1));
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en && !o_expire)
            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/tensor_core_seq.sv
// tensor_core_seq: K-step sequencer feeding a 4x4 MMA datapath (D = A*B + C).
// Optional TC_SEQ_BIAS_EN: seeds the accumulator from i_cmd_c on command accept.
module tensor_core_seq
    import tc_pkg::*;
#(
    parameter int DWIDTH  = tc_pkg::DWIDTH,
    parameter int KW      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [KW-1:0]         i_cmd_k,
`ifdef TC_SEQ_BIAS_EN
    input  logic [16*DWIDTH-1:0]  i_cmd_c,
`endif
    input  logic                  i_ab_valid,
    output logic                  o_ab_ready,
    input  logic [16*DWIDTH-1:0]  i_a_tile,
    input  logic [16*DWIDTH-1:0]  i_b_tile,
    output logic [16*DWIDTH-1:0]  o_mma_a,
    output logic [16*DWIDTH-1:0]  o_mma_b,
    output logic [16*DWIDTH-1:0]  o_mma_c,
    output logic                  o_mma_in_valid,
    input  logic [16*DWIDTH-1:0]  i_mma_c_out,
    input  logic                  i_mma_out_valid,
    output logic                  o_res_valid,
    input  logic                  i_res_ready,
    output logic [16*DWIDTH-1:0]  o_res_c,
    output logic                  o_busy,
    output logic                  o_err_timeout
);
    seq_state_t r_state, w_next;
    logic [16*DWIDTH-1:0] r_acc, r_a, r_b, w_init;
    logic [KW-1:0] r_rem;
    logic r_err, w_cmd_hs, w_ab_hs, w_ret, w_expire, w_exec;

    assign w_exec   = (r_state == EXEC);
    assign w_cmd_hs = (r_state == IDLE) && i_cmd_valid;
    assign w_ab_hs  = (r_state == FETCH) && i_ab_valid;
    assign w_ret    = w_exec && i_mma_out_valid;

`ifdef TC_SEQ_BIAS_EN
    assign w_init = i_cmd_c;
`else
    assign w_init = '0;
`endif

    tc_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clr    (!w_exec),
        .i_en     (w_exec),
        .o_expire (w_expire)
    );

    // A result landing on the expiry cycle wins over the abort
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_cmd_valid) w_next = (i_cmd_k == '0) ? DONE : FETCH;
            FETCH:   if (i_ab_valid) w_next = EXEC;
            EXEC:    if (i_mma_out_valid) w_next = (r_rem == KW'(1)) ? DONE : FETCH;
                     else if (w_expire) w_next = IDLE;
            DONE:    if (i_res_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_rem   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_cmd_hs) begin
                r_acc <= w_init;
                r_rem <= i_cmd_k;
                r_err <= 1'b0;
            end
            if (w_ab_hs) begin
                r_a <= i_a_tile;
                r_b <= i_b_tile;
            end
            if (w_ret) begin
                r_acc <= i_mma_c_out;
                r_rem <= r_rem - 1'b1;
            end
            if (w_expire && !w_ret)
                r_err <= 1'b1;
        end
    end

    assign o_cmd_ready    = (r_state == IDLE);
    assign o_ab_ready     = (r_state == FETCH);
    assign o_mma_in_valid = w_exec;
    assign o_res_valid    = (r_state == DONE);
    assign o_busy         = (r_state != IDLE);
    assign o_mma_a        = r_a;
    assign o_mma_b        = r_b;
    assign o_mma_c        = r_acc;
    assign o_res_c        = r_acc;
    assign o_err_timeout  = r_err;
endmodule

// File: tb/tb_tensor_core_seq.sv
// tb_tensor_core_seq: random-stimulus bench with an integer MMA stub and reference model.
module tb_tensor_core_seq;
    import tc_pkg::*;

    logic clk = 0, rst_n = 0;
    logic cmd_valid = 0, ab_valid = 0, res_ready = 0;
    logic [7:0] cmd_k = 0;
    tile_t a_tile = '0, b_tile = '0, cmd_c = '0, junk = '0;
    logic cmd_ready, ab_ready, mma_in_valid, mma_out_valid, res_valid, busy, err_timeout;
    tile_t mma_a, mma_b, mma_c, mma_c_out, res_c;
    int stub_lat = 0, stub_cnt = 0, n_chk = 0, n_fail = 0, iv_pulses = 0, res_cnt = 0;
    logic stub_dead = 0, force_ov = 0, prev_iv = 0;

    always #5 clk = ~clk;

    tensor_core_seq #(.DWIDTH(16), .KW(8), .TIMEOUT(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_k(cmd_k),
`ifdef TC_SEQ_BIAS_EN
        .i_cmd_c(cmd_c),
`endif
        .i_ab_valid(ab_valid), .o_ab_ready(ab_ready), .i_a_tile(a_tile), .i_b_tile(b_tile),
        .o_mma_a(mma_a), .o_mma_b(mma_b), .o_mma_c(mma_c), .o_mma_in_valid(mma_in_valid),
        .i_mma_c_out(mma_c_out), .i_mma_out_valid(mma_out_valid),
        .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_c(res_c),
        .o_busy(busy), .o_err_timeout(err_timeout)
    );

    // Integer stand-in for fp16 multiply; 16'h3C00 (fp16 one) acts as the identity
    function automatic logic [15:0] mul16(input logic [15:0] x, input logic [15:0] y);
        if (x == 16'h3C00) return y;
        if (y == 16'h3C00) return x;
        return 16'(x * y);
    endfunction

    function automatic tile_t mma_ref(input tile_t a, input tile_t b, input tile_t c);
        tile_t d;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                d[i][j] = c[i][j];
                for (int k = 0; k < 4; k++) d[i][j] += mul16(a[i][k], b[k][j]);
            end
        return d;
    endfunction

    function automatic tile_t rnd_tile();
        tile_t t;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) t[i][j] = 16'($urandom);
        return t;
    endfunction

    always_comb begin
        mma_out_valid = force_ov || (!stub_dead && mma_in_valid && stub_cnt == stub_lat);
        mma_c_out = force_ov ? junk : mma_ref(mma_a, mma_b, mma_c);
    end

    always @(posedge clk) begin
        stub_cnt <= (mma_in_valid && !mma_out_valid) ? stub_cnt + 1 : 0;
        prev_iv <= mma_in_valid;
        if (mma_in_valid && !prev_iv) iv_pulses <= iv_pulses + 1;
        if (res_valid) res_cnt <= res_cnt + 1;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_cmd(input int k, input int gap, input int lat, input int hold, input bit ident);
        tile_t exp, a, b, fill;
        int cyc, p0;
        stub_lat = lat;
        exp = '0;
`ifdef TC_SEQ_BIAS_EN
        cmd_c = rnd_tile();
        exp = cmd_c;
`endif
        p0 = iv_pulses;
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1;
        cmd_k = 8'(k);
        @(negedge clk);
        cmd_valid = 0;
        cmd_k = 8'($urandom);
        check("err_cleared", err_timeout, 0);
        for (int s = 0; s < k; s++) begin
            for (int g = 0; g < gap; g++) begin
                check("no_res_early", res_valid, 0);
                @(negedge clk);
            end
            check("ab_ready", ab_ready, 1);
            a = rnd_tile();
            b = rnd_tile();
            if (ident) begin
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++) begin
                        a[i][j] = (i == j) ? 16'h3C00 : 16'h0000;
                        b[i][j] = 16'h4000;
                    end
            end
            a_tile = a;
            b_tile = b;
            ab_valid = 1;
            @(negedge clk);
            ab_valid = 0;
            a_tile = rnd_tile();
            b_tile = rnd_tile();
            check("mma_in_valid", mma_in_valid, 1);
            check("mma_a", mma_a, a);
            check("mma_b", mma_b, b);
            check("mma_c_chain", mma_c, exp);
            cyc = 1;
            while (!mma_out_valid && cyc < 200) begin
                @(negedge clk);
                cyc++;
                check("ops_stable", {mma_in_valid, mma_a == a, mma_b == b, mma_c == exp}, 4'hF);
            end
            check("exec_cycles", cyc, lat + 1);
            exp = mma_ref(a, b, exp);
            @(negedge clk);
        end
        check("res_valid", res_valid, 1);
        check("res_c", res_c, exp);
        check("in_valid_pulses", iv_pulses - p0, k);
`ifndef TC_SEQ_BIAS_EN
        if (ident) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) fill[i][j] = 16'h4000;
            check("ident_res", res_c, fill);
        end
`endif
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_state", {res_valid, busy, cmd_ready, res_c == exp}, 4'b1101);
        end
        res_ready = 1;
        @(negedge clk);
        res_ready = 0;
        check("back_idle", {busy, res_valid, cmd_ready}, 3'b001);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int cyc, r0;
        tile_t a;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {cmd_ready, ab_ready, mma_in_valid, res_valid, busy, err_timeout}, 6'b100000);
        check("rst_bus", {mma_a, mma_b, mma_c, res_c} == '0, 1);
        rst_n = 1;
        @(negedge clk);

        run_cmd(1, 0, 0, 0, 1);
        run_cmd(3, 2, 0, 0, 0);
        run_cmd(0, 0, 0, 0, 0);
        run_cmd(2, 0, 1, 5, 0);
        for (int n = 0; n < 6; n++)
            run_cmd($urandom_range(1, 4), $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2), 0);
        run_cmd(2, 0, 14, 0, 0);

        // datapath never answers: abort after TIMEOUT EXEC cycles
        stub_dead = 1;
        r0 = res_cnt;
        cmd_valid = 1;
        cmd_k = 8'd2;
        @(negedge clk);
        cmd_valid = 0;
        a_tile = rnd_tile();
        ab_valid = 1;
        @(negedge clk);
        ab_valid = 0;
        cyc = 0;
        while (mma_in_valid && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        check("timeout_cycles", cyc, 16);
        check("timeout_state", {err_timeout, busy, cmd_ready, res_valid}, 4'b1010);
        check("timeout_no_res", res_cnt - r0, 0);
        stub_dead = 0;
        run_cmd(1, 1, 2, 0, 0);

        // async reset in the middle of a latency-4 EXEC after one finished step
        stub_lat = 4;
        r0 = res_cnt;
        cmd_valid = 1;
        cmd_k = 8'd2;
        @(negedge clk);
        cmd_valid = 0;
        for (int s = 0; s < 2; s++) begin
            a_tile = rnd_tile();
            b_tile = rnd_tile();
            ab_valid = 1;
            @(negedge clk);
            ab_valid = 0;
            repeat (s == 0 ? 5 : 2) @(negedge clk);
        end
        a = mma_c;
        check("pre_rst_exec", mma_in_valid, 1);
        #2 rst_n = 0;
        #1;
        check("async_rst_ctrl", {mma_in_valid, busy, res_valid, cmd_ready}, 4'b0001);
        check("async_rst_acc", {mma_c, mma_a, mma_b} == '0, 1);
        @(negedge clk);
        rst_n = 1;
        junk = rnd_tile();
        force_ov = 1;
        repeat (3) @(negedge clk);
        force_ov = 0;
        check("late_ov_acc", mma_c, 0);
        check("late_ov_idle", {busy, mma_in_valid, cmd_ready}, 3'b001);
        check("rst_no_res", res_cnt - r0, 0);
        run_cmd(2, 1, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
